fence_sequencer: RTL and testbench

- Backend controller that sequences FENCE and FENCE.I at the dispatch stage.
- When dispatch presents a fence, the block holds further dispatch and waits for the store FIFO and/or load buffer to drain, as required by the pred/succ fields.
- For FENCE.I it also runs an I-cache flush handshake, then grants a single-cycle acknowledge so dispatch can push the fence into the reorder FIFO.
- Pipeline flush aborts a sequence in progress.

---
 rtl/fence_sequencer.sv | 120 ++++++++++++
 tb/tb_fence_sequencer.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fence_sequencer.sv
// Dispatch-stage FENCE / FENCE.I sequencer.
// Holds dispatch, drains memory queues, optionally flushes I-cache, then acks.
module fence_sequencer #(
  parameter int LU_DP      = 4,
  parameter int SETTLE_CYC = 2,
  parameter int STAT_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              fence_req,
  input  logic              fence_i,
  input  logic [3:0]        fence_pred,
  input  logic [3:0]        fence_succ,
  input  logic              su_fifo_empty,
  input  logic [LU_DP-1:0]  lu_buffer_malloc,
  input  logic              flush,
  input  logic              icache_flush_ack,
  output logic              fence_ack,
  output logic              dispat_hold,
  output logic              icache_flush_req,
  output logic [STAT_W-1:0] stall_cycles
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SETTLE,
    IFLUSH,
    ACK
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic                r_fence_i;
  logic                r_wait_su;
  logic                r_wait_lu;
  logic                r_abort_pend;
  logic [3:0]          r_cnt;
  logic [STAT_W-1:0]   r_stall;
  logic                w_wait_su;
  logic                w_wait_lu;
  logic                w_done;
  logic                w_accept;

  assign w_wait_su = fence_i |
    ((fence_pred[2] | fence_pred[0]) & (|fence_succ));
  assign w_wait_lu = fence_i |
    ((fence_pred[3] | fence_pred[1]) & (|fence_succ));
  assign w_done = (~r_wait_su | su_fifo_empty) &
                  (~r_wait_lu | ~(|lu_buffer_malloc));
  assign w_accept = fence_req & ~flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_wait_su | w_wait_lu) w_state_n = DRAIN;
          else if (fence_i)          w_state_n = IFLUSH;
          else                       w_state_n = ACK;
        end
      end
      DRAIN: begin
        if (flush)       w_state_n = IDLE;
        else if (w_done) w_state_n = SETTLE;
      end
      SETTLE: begin
        if (flush)            w_state_n = IDLE;
        else if (!w_done)     w_state_n = DRAIN;
        else if (r_cnt == '0) w_state_n = r_fence_i ? IFLUSH : ACK;
      end
      // A flush here cannot cancel the I-cache request; it only
      // turns the eventual ack into a silent return to IDLE.
      IFLUSH: begin
        if (icache_flush_ack)
          w_state_n = (r_abort_pend | flush) ? IDLE : ACK;
      end
      ACK:     w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fence_i    <= 1'b0;
      r_wait_su    <= 1'b0;
      r_wait_lu    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_cnt        <= '0;
      r_stall      <= '0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_fence_i <= fence_i;
        r_wait_su <= w_wait_su;
        r_wait_lu <= w_wait_lu;
      end
      if (w_state_n == IDLE)
        r_abort_pend <= 1'b0;
      else if (r_state == IFLUSH && flush)
        r_abort_pend <= 1'b1;
      if (r_state == DRAIN && w_state_n == SETTLE)
        r_cnt <= 4'(SETTLE_CYC - 1);
      else if (r_state == SETTLE && w_state_n == SETTLE)
        r_cnt <= r_cnt - 4'd1;
      if (r_state != IDLE)
        r_stall <= r_stall + STAT_W'(1);
    end
  end

  assign fence_ack        = (r_state == ACK) & ~flush;
  assign dispat_hold      = (r_state != IDLE);
  assign icache_flush_req = (r_state == IFLUSH);
  assign stall_cycles     = r_stall;

endmodule

// File: tb/tb_fence_sequencer.sv
// Directed self-checking bench for fence_sequencer.
// A second instance with a 4-bit counter exercises statistics wrap.
module tb_fence_sequencer;

  logic        CLK;
  logic        RST;
  logic        fence_req;
  logic        fence_i;
  logic [3:0]  fence_pred;
  logic [3:0]  fence_succ;
  logic        su_fifo_empty;
  logic [3:0]  lu_buffer_malloc;
  logic        flush;
  logic        icache_flush_ack;
  logic        fence_ack;
  logic        dispat_hold;
  logic        icache_flush_req;
  logic [31:0] stall_cycles;
  logic        w_ack2;
  logic        w_hold2;
  logic        w_ireq2;
  logic [3:0]  w_stall2;

  int chk;
  int fail;

  fence_sequencer #(.LU_DP(4), .SETTLE_CYC(2), .STAT_W(32)) u_dut (
    .CLK(CLK), .RST(RST),
    .fence_req(fence_req), .fence_i(fence_i),
    .fence_pred(fence_pred), .fence_succ(fence_succ),
    .su_fifo_empty(su_fifo_empty),
    .lu_buffer_malloc(lu_buffer_malloc),
    .flush(flush), .icache_flush_ack(icache_flush_ack),
    .fence_ack(fence_ack), .dispat_hold(dispat_hold),
    .icache_flush_req(icache_flush_req),
    .stall_cycles(stall_cycles)
  );

  fence_sequencer #(.LU_DP(4), .SETTLE_CYC(2), .STAT_W(4)) u_wrap (
    .CLK(CLK), .RST(RST),
    .fence_req(fence_req), .fence_i(fence_i),
    .fence_pred(fence_pred), .fence_succ(fence_succ),
    .su_fifo_empty(su_fifo_empty),
    .lu_buffer_malloc(lu_buffer_malloc),
    .flush(flush), .icache_flush_ack(icache_flush_ack),
    .fence_ack(w_ack2), .dispat_hold(w_hold2),
    .icache_flush_req(w_ireq2),
    .stall_cycles(w_stall2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    fence_req = 1'b0;
    fence_i = 1'b0;
    fence_pred = 4'h0;
    fence_succ = 4'h0;
    su_fifo_empty = 1'b1;
    lu_buffer_malloc = 4'h0;
    flush = 1'b0;
    icache_flush_ack = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    RST = 1'b1;
    tick();
    chk++;
    if ({fence_ack, dispat_hold, icache_flush_req} !== 3'b000) begin
      fail++;
      $display("FAIL reset_outs got=%b exp=000",
        {fence_ack, dispat_hold, icache_flush_req});
    end
    chk++;
    if (stall_cycles !== 32'd0) begin
      fail++;
      $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
    end
    RST = 1'b0;
  endtask

  task automatic test_no_wait();
    logic [7:0] vec [2];
    logic [7:0] v;
    vec[0] = 8'b0000_1111;
    vec[1] = 8'b1010_0000;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      v = vec[i];
      fence_pred = v[7:4];
      fence_succ = v[3:0];
      su_fifo_empty = 1'b0;
      lu_buffer_malloc = 4'hf;
      fence_req = 1'b1;
      tick();
      chk++;
      if ({fence_ack, dispat_hold, icache_flush_req} !== 3'b110) begin
        fail++;
        $display("FAIL nowait_ack%0d got=%b exp=110", i,
          {fence_ack, dispat_hold, icache_flush_req});
      end
      fence_req = 1'b0;
      tick();
      chk++;
      if ({fence_ack, dispat_hold} !== 2'b00) begin
        fail++;
        $display("FAIL nowait_idle%0d got=%b exp=00", i,
          {fence_ack, dispat_hold});
      end
      chk++;
      if (stall_cycles !== 32'd1) begin
        fail++;
        $display("FAIL nowait_stall%0d got=%0d exp=1", i, stall_cycles);
      end
    end
  endtask

  task automatic test_drain_su();
    int early;
    do_reset();
    fence_pred = 4'b0011;
    fence_succ = 4'b0011;
    su_fifo_empty = 1'b0;
    fence_req = 1'b1;
    early = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (fence_ack !== 1'b0 || dispat_hold !== 1'b1) early++;
    end
    chk++;
    if (early != 0) begin
      fail++;
      $display("FAIL drain_su_hold got=%0d bad cycles exp=0", early);
    end
    su_fifo_empty = 1'b1;
    tick();
    tick();
    chk++;
    if (fence_ack !== 1'b0) begin
      fail++;
      $display("FAIL drain_su_settle got=%b exp=0", fence_ack);
    end
    tick();
    chk++;
    if (fence_ack !== 1'b1) begin
      fail++;
      $display("FAIL drain_su_ack got=%b exp=1", fence_ack);
    end
    fence_req = 1'b0;
    tick();
    chk++;
    if (dispat_hold !== 1'b0 || stall_cycles !== 32'd13) begin
      fail++;
      $display("FAIL drain_su_stall got=%b/%0d exp=0/13",
        dispat_hold, stall_cycles);
    end
  endtask

  task automatic test_lu_only();
    do_reset();
    fence_pred = 4'b0010;
    fence_succ = 4'b0001;
    su_fifo_empty = 1'b0;
    fence_req = 1'b1;
    tick();
    tick();
    tick();
    chk++;
    if (fence_ack !== 1'b0) begin
      fail++;
      $display("FAIL lu_only_early got=%b exp=0", fence_ack);
    end
    tick();
    chk++;
    if (fence_ack !== 1'b1) begin
      fail++;
      $display("FAIL lu_only_ack got=%b exp=1", fence_ack);
    end
    fence_req = 1'b0;
    tick();
  endtask

  task automatic test_fencei();
    int bad;
    do_reset();
    fence_i = 1'b1;
    lu_buffer_malloc = 4'b0100;
    fence_req = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (fence_ack !== 1'b0 || icache_flush_req !== 1'b0) bad++;
    end
    lu_buffer_malloc = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (fence_ack !== 1'b0 || icache_flush_req !== 1'b0) bad++;
    end
    chk++;
    if (bad != 0) begin
      fail++;
      $display("FAIL fencei_pre got=%0d bad cycles exp=0", bad);
    end
    tick();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (icache_flush_req !== 1'b1 || fence_ack !== 1'b0) bad++;
      if (k < 4) tick();
    end
    chk++;
    if (bad != 0) begin
      fail++;
      $display("FAIL fencei_iflush got=%0d bad cycles exp=0", bad);
    end
    icache_flush_ack = 1'b1;
    tick();
    icache_flush_ack = 1'b0;
    chk++;
    if ({fence_ack, icache_flush_req} !== 2'b10) begin
      fail++;
      $display("FAIL fencei_ack got=%b exp=10",
        {fence_ack, icache_flush_req});
    end
    fence_req = 1'b0;
    tick();
    chk++;
    if (dispat_hold !== 1'b0) begin
      fail++;
      $display("FAIL fencei_idle got=%b exp=0", dispat_hold);
    end
  endtask

  task automatic test_settle_reassert();
    do_reset();
    fence_pred = 4'b0011;
    fence_succ = 4'b0011;
    fence_req = 1'b1;
    tick();
    tick();
    lu_buffer_malloc = 4'b0001;
    tick();
    lu_buffer_malloc = 4'b0000;
    tick();
    tick();
    chk++;
    if (fence_ack !== 1'b0) begin
      fail++;
      $display("FAIL settle_restart got=%b exp=0", fence_ack);
    end
    tick();
    chk++;
    if (fence_ack !== 1'b1) begin
      fail++;
      $display("FAIL settle_ack got=%b exp=1", fence_ack);
    end
    fence_req = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    fence_i = 1'b1;
    fence_req = 1'b1;
    tick();
    tick();
    tick();
    tick();
    flush = 1'b1;
    fence_req = 1'b0;
    tick();
    flush = 1'b0;
    chk++;
    if ({icache_flush_req, dispat_hold, fence_ack} !== 3'b110) begin
      fail++;
      $display("FAIL flush_iflush_hold got=%b exp=110",
        {icache_flush_req, dispat_hold, fence_ack});
    end
    tick();
    icache_flush_ack = 1'b1;
    tick();
    icache_flush_ack = 1'b0;
    chk++;
    if ({icache_flush_req, dispat_hold, fence_ack} !== 3'b000) begin
      fail++;
      $display("FAIL flush_iflush_idle got=%b exp=000",
        {icache_flush_req, dispat_hold, fence_ack});
    end
    fence_i = 1'b1;
    fence_req = 1'b1;
    repeat (4) tick();
    icache_flush_ack = 1'b1;
    tick();
    icache_flush_ack = 1'b0;
    chk++;
    if (fence_ack !== 1'b1) begin
      fail++;
      $display("FAIL flush_abort_clear got=%b exp=1", fence_ack);
    end
    fence_req = 1'b0;
    fence_i = 1'b0;
    tick();
    fence_pred = 4'b0001;
    fence_succ = 4'b0001;
    su_fifo_empty = 1'b0;
    fence_req = 1'b1;
    tick();
    flush = 1'b1;
    fence_req = 1'b0;
    tick();
    flush = 1'b0;
    chk++;
    if ({dispat_hold, fence_ack} !== 2'b00) begin
      fail++;
      $display("FAIL flush_drain got=%b exp=00", {dispat_hold, fence_ack});
    end
    fence_pred = 4'b0000;
    fence_req = 1'b1;
    tick();
    flush = 1'b1;
    fence_req = 1'b0;
    #1;
    chk++;
    if (fence_ack !== 1'b0 || dispat_hold !== 1'b1) begin
      fail++;
      $display("FAIL flush_ack_gate got=%b/%b exp=0/1",
        fence_ack, dispat_hold);
    end
    tick();
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    fence_req = 1'b1;
    tick();
    chk++;
    if (fence_ack !== 1'b1) begin
      fail++;
      $display("FAIL b2b_first got=%b exp=1", fence_ack);
    end
    tick();
    chk++;
    if ({fence_ack, dispat_hold} !== 2'b00) begin
      fail++;
      $display("FAIL b2b_gap got=%b exp=00", {fence_ack, dispat_hold});
    end
    tick();
    chk++;
    if (fence_ack !== 1'b1) begin
      fail++;
      $display("FAIL b2b_second got=%b exp=1", fence_ack);
    end
    fence_req = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid();
    do_reset();
    fence_pred = 4'b0001;
    fence_succ = 4'b0001;
    su_fifo_empty = 1'b0;
    fence_req = 1'b1;
    repeat (8) tick();
    chk++;
    if (stall_cycles !== 32'd7 || dispat_hold !== 1'b1) begin
      fail++;
      $display("FAIL rst_pre got=%0d/%b exp=7/1", stall_cycles, dispat_hold);
    end
    RST = 1'b1;
    #1;
    chk++;
    if ({fence_ack, dispat_hold, icache_flush_req} !== 3'b000 ||
        stall_cycles !== 32'd0) begin
      fail++;
      $display("FAIL rst_mid_drain got=%b/%0d exp=000/0",
        {fence_ack, dispat_hold, icache_flush_req}, stall_cycles);
    end
    do_reset();
    fence_i = 1'b1;
    fence_req = 1'b1;
    repeat (4) tick();
    RST = 1'b1;
    #1;
    chk++;
    if (icache_flush_req !== 1'b0 || dispat_hold !== 1'b0) begin
      fail++;
      $display("FAIL rst_mid_iflush got=%b/%b exp=0/0",
        icache_flush_req, dispat_hold);
    end
    RST = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    fence_pred = 4'b0001;
    fence_succ = 4'b0001;
    su_fifo_empty = 1'b0;
    fence_req = 1'b1;
    repeat (16) tick();
    chk++;
    if (w_stall2 !== 4'd15) begin
      fail++;
      $display("FAIL wrap_max got=%0d exp=15", w_stall2);
    end
    tick();
    chk++;
    if (w_stall2 !== 4'd0 || stall_cycles !== 32'd16) begin
      fail++;
      $display("FAIL wrap_zero got=%0d/%0d exp=0/16",
        w_stall2, stall_cycles);
    end
    flush = 1'b1;
    fence_req = 1'b0;
    tick();
    flush = 1'b0;
    tick();
    chk++;
    if (stall_cycles !== 32'd17) begin
      fail++;
      $display("FAIL stall_kept_on_flush got=%0d exp=17", stall_cycles);
    end
  endtask

  initial begin
    chk = 0;
    fail = 0;
    test_reset();
    test_no_wait();
    test_drain_su();
    test_lu_only();
    test_fencei();
    test_settle_reassert();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
    $finish;
  end

endmodule
